uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_pkg.sv | 26 ++
 rtl/baud_gen.sv | 32 +++
 rtl/uart_tx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
// Holds the FSM state encoding, default frame geometry and a counter-width helper.

package uart_tx_fifo_pkg;

    // Default frame geometry
    localparam int DATA_WIDTH_DEF = 8;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int SB_TICKS_DEF   = 16;

    // Default baud divisor: a tick on every clock
    localparam int BAUD_DIV_DEF   = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } tx_state_e;

    // Width able to hold 0 .. n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/baud_gen.sv
// Oversample tick generator: one-clock strobe every DIVISOR clocks.
// Ports: i_clock, i_reset (async, active low) -> o_tick (registered strobe).

module baud_gen
    import uart_tx_fifo_pkg::*;
#(
    parameter int DIVISOR = BAUD_DIV_DEF
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_tick
);

    localparam int            CW   = cnt_width(DIVISOR);
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt    <= '0;
            o_tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt    <= '0;
            o_tick <= 1'b1;
        end else begin
            cnt    <= cnt + 1'b1;
            o_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter that pulls words from a TX FIFO and sends 8N1-style frames.
// Ports: i_clock, i_reset (async, active low), i_tick (oversample strobe),
//        i_txff_empty / i_txff_data (FIFO head), o_txff_read (pop strobe),
//        o_tx (serial line, idle high), o_busy (frame in progress).

module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int SB_TICKS   = SB_TICKS_DEF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_tick,
    input  logic                  i_txff_empty,
    input  logic [DATA_WIDTH-1:0] i_txff_data,
    output logic                  o_txff_read,
    output logic                  o_tx,
    output logic                  o_busy
);

    // One tick counter serves both the bit periods and the stop period
    localparam int TMAX = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
    localparam int TW   = cnt_width(TMAX);
    localparam int BW   = cnt_width(DATA_WIDTH);

    localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICKS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    tx_state_e             state;
    tx_state_e             state_n;
    logic [TW-1:0]         tick_cnt;
    logic [TW-1:0]         tick_cnt_n;
    logic [BW-1:0]         bit_cnt;
    logic [BW-1:0]         bit_cnt_n;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_n;
    logic                  read_n;
    logic                  tx_n;
    logic                  busy_n;

    // State, counters and shift register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
        end
    end

    // Next-state logic; without i_tick every busy state simply holds
    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        read_n     = 1'b0;

        unique case (state)
            IDLE: begin
                // Tick on the capture edge is deliberately ignored
                if (!i_txff_empty) begin
                    shreg_n    = i_txff_data;
                    tick_cnt_n = '0;
                    bit_cnt_n  = '0;
                    read_n     = 1'b1;
                    state_n    = START;
                end
            end

            START: begin
                if (i_tick) begin
                    if (tick_cnt == OS_LAST) begin
                        tick_cnt_n = '0;
                        state_n    = DATA;
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end

            DATA: begin
                if (i_tick) begin
                    if (tick_cnt == OS_LAST) begin
                        tick_cnt_n = '0;
                        shreg_n    = shreg >> 1;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt_n = '0;
                            state_n   = STOP;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end

            STOP: begin
                if (i_tick) begin
                    if (tick_cnt == SB_LAST) begin
                        tick_cnt_n = '0;
                        state_n    = IDLE;
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Line level follows the current state, so the start bit
    // appears the cycle after the pop strobe
    always_comb begin
        tx_n = 1'b1;
        unique case (state)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg[0];
            default: tx_n = 1'b1;
        endcase
    end

    // Busy spans the pop cycle through the last stop-level cycle
    assign busy_n = (state != IDLE) || (state_n != IDLE);

    // Registered outputs
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_tx        <= 1'b1;
            o_txff_read <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_tx        <= tx_n;
            o_txff_read <= read_n;
            o_busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo.
// Tick-counting line model, queue-based FIFO, directed and random frames.

module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int OS    = 16;
    localparam int SB    = 16;
    localparam int TOTAL = (1 + DW) * OS + SB;
    localparam int GAP   = TOTAL + 1;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          tick_r = 1'b0;
    logic          i_tick;
    logic          bg_tick;
    logic          empty  = 1'b1;
    logic [DW-1:0] data   = '0;
    logic          rd;
    logic          tx;
    logic          busy;

    int tick_mode = 0;

    assign i_tick = (tick_mode == 1) ? bg_tick : tick_r;

    always #5 clk = ~clk;

    baud_gen #(.DIVISOR(4)) u_baud (
        .i_clock (clk),
        .i_reset (rst_n),
        .o_tick  (bg_tick)
    );

    uart_tx_fifo #(
        .DATA_WIDTH (DW),
        .OVERSAMPLE (OS),
        .SB_TICKS   (SB)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_tick       (i_tick),
        .i_txff_empty (empty),
        .i_txff_data  (data),
        .o_txff_read  (rd),
        .o_tx         (tx),
        .o_busy       (busy)
    );

    logic [DW-1:0] fifo[$];

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    // Reference model state
    bit            act        = 1'b0;
    logic [DW-1:0] fdat       = '0;
    int            t_prev     = 0;
    int            t_cur      = 0;
    bit            idle_p     = 1'b1;
    bit            nonempty_p = 1'b0;
    bit            tick_p     = 1'b0;
    bit            rst_edge   = 1'b0;
    bit            rd_obs     = 1'b0;
    logic [DW-1:0] data_p     = '0;
    int            cyc        = 0;
    int            pops       = 0;
    int            last_pop   = 0;
    int            pop_gap    = 0;
    int            last_bg    = -1;
    int            hi_cnt     = 0;

    // Line level after t ticks of a frame carrying d
    function automatic logic level(input logic [DW-1:0] d, input int t);
        logic [DW-1:0] sh;
        if (t < OS) return 1'b0;
        if (t < (1 + DW) * OS) begin
            sh = d >> ((t - OS) / OS);
            return sh[0];
        end
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic e_tx;
        logic e_busy;
        logic e_rd;
        bit   idle_c;
        cyc++;
        e_tx   = 1'b1;
        e_busy = 1'b0;
        e_rd   = 1'b0;
        idle_c = 1'b1;
        if (!rst_n) begin
            act = 1'b0;
        end else if (rst_edge && idle_p && nonempty_p) begin
            e_rd   = 1'b1;
            act    = 1'b1;
            fdat   = data_p;
            t_cur  = 0;
            t_prev = 0;
            e_busy = 1'b1;
            idle_c = 1'b0;
        end else if (act) begin
            t_prev = t_cur;
            t_cur  = t_cur + int'(tick_p);
            if (t_prev < TOTAL) begin
                e_tx   = level(fdat, t_prev);
                e_busy = 1'b1;
            end else begin
                act = 1'b0;
            end
            idle_c = (t_cur >= TOTAL);
        end
        check("o_tx", 32'(tx), 32'(e_tx));
        check("o_busy", 32'(busy), 32'(e_busy));
        check("o_txff_read", 32'(rd), 32'(e_rd));
        if (tx === 1'b1 && busy === 1'b1 && rd === 1'b0) hi_cnt++;
        if (rd === 1'b1) begin
            pops++;
            pop_gap  = cyc - last_pop;
            last_pop = cyc;
        end
        if (tick_mode == 1 && bg_tick === 1'b1) begin
            if (last_bg >= 0) check("tick_gap", 32'(cyc - last_bg), 32'd4);
            last_bg = cyc;
        end
        rd_obs     = (rd === 1'b1);
        idle_p     = idle_c;
        nonempty_p = !empty;
        data_p     = data;
        tick_p     = (i_tick === 1'b1);
    endtask

    task automatic cycle();
        @(posedge clk);
        rst_edge = rst_n;
        #1;
        if (rd_obs && fifo.size() > 0) void'(fifo.pop_front());
        case (tick_mode)
            0:       tick_r = 1'b1;
            2:       tick_r = ($urandom_range(0, 1) == 1);
            default: tick_r = 1'b0;
        endcase
        empty = (fifo.size() == 0);
        data  = empty ? DW'($urandom) : fifo[0];
        @(negedge clk);
        model_step();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_read(input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (rd_obs) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic drain(input int budget, input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (fifo.size() == 0 && !act && !rd_obs) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        // Reset state, FIFO loaded while held in reset
        rst_n = 1'b0;
        run(3);
        fifo.push_back(8'h55);
        #2 rst_n = 1'b1;

        // 0x55 with a tick every cycle
        pops = 0;
        wait_read(5, "pop_55");
        drain(400, "drain_55");
        check("pops_55", 32'(pops), 32'd1);

        // Empty FIFO, ticks running
        pops = 0;
        run(500);
        check("pops_empty", 32'(pops), 32'd0);

        // Back-to-back 0x01 then 0xFF
        pops = 0;
        fifo.push_back(8'h01);
        fifo.push_back(8'hFF);
        drain(600, "drain_b2b");
        check("pops_b2b", 32'(pops), 32'd2);
        check("pop_gap", 32'(pop_gap), 32'(GAP));

        // Reset during data bit 3 of 0xA5
        fifo.push_back(8'hA5);
        wait_read(5, "pop_a5");
        run(70);
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_read", 32'(rd), 32'd0);
        fifo.push_front(8'hA5);
        pops = 0;
        run(4);
        #2 rst_n = 1'b1;
        wait_read(5, "pop_a5_again");
        drain(400, "drain_a5");
        check("pops_a5", 32'(pops), 32'd1);

        // 0x80 with a tick every 4th cycle from baud_gen
        tick_mode = 1;
        last_bg   = -1;
        hi_cnt    = 0;
        pops      = 0;
        fifo.push_back(8'h80);
        wait_read(8, "pop_80");
        drain(900, "drain_80");
        check("pops_80", 32'(pops), 32'd1);
        check("hi_80", 32'(hi_cnt), 32'(2 * 4 * OS));

        // 0x3C with the FIFO head changing mid-frame
        tick_mode = 0;
        pops      = 0;
        fifo.push_back(8'h3C);
        wait_read(5, "pop_3c");
        run(40);
        fifo.push_back(8'hC3);
        drain(500, "drain_3c");
        check("pops_3c", 32'(pops), 32'd2);

        // Random words, random tick pattern, random arrival gaps
        tick_mode = 2;
        pops      = 0;
        for (int k = 0; k < 6; k++) begin
            fifo.push_back(DW'($urandom));
            run($urandom_range(0, 200));
        end
        drain(5000, "drain_rand");
        check("pops_rand", 32'(pops), 32'd6);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
